// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encodings and lamp patterns shared by the intersection controller
package traffic_pkg;
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    PED_WALK    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6,
    NIGHT_FLASH = 3'd7
  } phase_t;
  localparam logic [2:0] RYG_RED = 3'b100;
  localparam logic [2:0] RYG_YEL = 3'b010;
  localparam logic [2:0] RYG_GRN = 3'b001;
  localparam logic [2:0] RYG_OFF = 3'b000;
endpackage

// File: rtl/traffic_ctrl_2way_phase_timer.sv
// phase_timer: loadable down-counter that parks at zero and flags it
module phase_timer #(
  parameter int TMR_W = 8,
  parameter logic [TMR_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);
  logic [TMR_W-1:0] cnt;
  // reload on phase entry, otherwise count down and stay at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= RST_VAL;
    else cnt <= load ? load_val : zero ? cnt : cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/traffic_ctrl_2way.sv
// traffic_ctrl_2way: two-road intersection controller with side-car and pedestrian requests; NIGHT_FLASH_EN adds night flashing
module traffic_ctrl_2way
  import traffic_pkg::*;
#(
  parameter int T_GREEN_MAIN = 16,
  parameter int T_GREEN_SIDE = 8,
  parameter int T_YELLOW     = 4,
  parameter int T_ALL_RED    = 2,
  parameter int T_WALK       = 6,
  parameter int T_FLASH      = 4,
  parameter int TMR_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_car,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);
  phase_t state, nxt;
  logic side_pend, ped_pend, tmr_zero, tmr_load, night_go, lit_nxt;
  logic [2:0] main_nxt, side_nxt;
  logic [TMR_W-1:0] load_val;

  function automatic logic [TMR_W-1:0] dur(input phase_t p);
    case (p)
      MAIN_GREEN:              return TMR_W'(T_GREEN_MAIN - 1);
      MAIN_YELLOW, SIDE_YELLOW: return TMR_W'(T_YELLOW - 1);
      PED_WALK:                return TMR_W'(T_WALK - 1);
      SIDE_GREEN:              return TMR_W'(T_GREEN_SIDE - 1);
      NIGHT_FLASH:             return TMR_W'(T_FLASH - 1);
      default:                 return TMR_W'(T_ALL_RED - 1);
    endcase
  endfunction

`ifdef NIGHT_FLASH_EN
  logic lit;
  assign night_go = night_mode;
  assign lit_nxt = (state != NIGHT_FLASH) | (tmr_zero ? ~lit : lit);
  // flash half-period phase: starts lit on entry, flips each time the timer expires
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lit <= 1'b1;
    else lit <= lit_nxt;
`else
  logic unused_night;
  assign night_go = 1'b0;
  assign lit_nxt = 1'b1;
  assign unused_night = night_mode;
`endif

  // next phase from timer expiry and latched requests, then lamps for that phase
  always_comb begin
    nxt = state;
    main_nxt = RYG_RED;
    side_nxt = RYG_RED;
    case (state)
      MAIN_GREEN:  if (tmr_zero) nxt = night_go ? NIGHT_FLASH : (side_pend | ped_pend) ? MAIN_YELLOW : MAIN_GREEN;
      MAIN_YELLOW: if (tmr_zero) nxt = ALL_RED_A;
      ALL_RED_A:   if (tmr_zero) nxt = ped_pend ? PED_WALK : SIDE_GREEN;
      PED_WALK:    if (tmr_zero) nxt = side_pend ? SIDE_GREEN : ALL_RED_B;
      SIDE_GREEN:  if (tmr_zero) nxt = SIDE_YELLOW;
      SIDE_YELLOW: if (tmr_zero) nxt = ALL_RED_B;
      ALL_RED_B:   if (tmr_zero) nxt = MAIN_GREEN;
`ifdef NIGHT_FLASH_EN
      NIGHT_FLASH: nxt = night_go ? NIGHT_FLASH : ALL_RED_B;
`endif
      default:     nxt = ALL_RED_B;
    endcase
    case (nxt)
      MAIN_GREEN:  main_nxt = RYG_GRN;
      MAIN_YELLOW: main_nxt = RYG_YEL;
      SIDE_GREEN:  side_nxt = RYG_GRN;
      SIDE_YELLOW: side_nxt = RYG_YEL;
      NIGHT_FLASH: begin
        main_nxt = lit_nxt ? RYG_YEL : RYG_OFF;
        side_nxt = lit_nxt ? RYG_RED : RYG_OFF;
      end
      default: ;
    endcase
  end

  assign tmr_load = (nxt != state) | (state == NIGHT_FLASH & tmr_zero);
  assign load_val = dur(nxt);

  phase_timer #(
    .TMR_W(TMR_W),
    .RST_VAL(TMR_W'(T_GREEN_MAIN - 1))
  ) u_tmr (
    .clk(clk),
    .rst_n(rst_n),
    .load(tmr_load),
    .load_val(load_val),
    .zero(tmr_zero)
  );

  // phase, request latches and lamps advance together; serving a request clears it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= MAIN_GREEN;
      side_pend <= 1'b0;
      ped_pend <= 1'b0;
      main_light <= RYG_GRN;
      side_light <= RYG_RED;
      walk <= 1'b0;
    end else begin
      state <= nxt;
      side_pend <= (nxt == SIDE_GREEN && state != SIDE_GREEN) ? 1'b0 :
                   (side_car && state != SIDE_GREEN && state != SIDE_YELLOW) ? 1'b1 : side_pend;
      ped_pend <= (nxt == PED_WALK && state != PED_WALK) ? 1'b0 :
                  (ped_req && state != PED_WALK) ? 1'b1 : ped_pend;
      main_light <= main_nxt;
      side_light <= side_nxt;
      walk <= nxt == PED_WALK;
    end

  assign phase = state;
endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// tb_traffic_ctrl_2way: directed scenarios checked against literal sequences and a phase-duration model
module tb_traffic_ctrl_2way;
  logic clk, rst_n, side_car, ped_req, night_mode;
  logic [2:0] main_light, side_light, phase;
  logic walk;
  int n_cmp = 0;
  int n_bad = 0;

`ifdef NIGHT_FLASH_EN
  localparam bit NIGHT = 1'b1;
`else
  localparam bit NIGHT = 1'b0;
`endif
  localparam int FLASH = 4;
  int dur [8] = '{4, 2, 1, 3, 3, 2, 1, 999};

  int m_p, m_e;
  bit m_sp, m_pp;

  traffic_ctrl_2way #(
    .T_GREEN_MAIN(4), .T_GREEN_SIDE(3), .T_YELLOW(2), .T_ALL_RED(1),
    .T_WALK(3), .T_FLASH(FLASH), .TMR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .side_car(side_car), .ped_req(ped_req),
    .night_mode(night_mode), .main_light(main_light), .side_light(side_light),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int next_phase(int p, int e, bit sp, bit pp, bit nm);
    bit done;
    done = e >= dur[p];
    case (p)
      0: return !done ? 0 : (NIGHT && nm) ? 7 : (sp || pp) ? 1 : 0;
      1: return done ? 2 : 1;
      2: return done ? (pp ? 3 : 4) : 2;
      3: return done ? (sp ? 4 : 6) : 3;
      4: return done ? 5 : 4;
      5: return done ? 6 : 5;
      6: return done ? 0 : 6;
      default: return nm ? 7 : 6;
    endcase
  endfunction

  function automatic logic [2:0] main_of(int p, int e);
    bit lit;
    lit = ((e - 1) / FLASH) % 2 == 0;
    return p == 0 ? 3'b001 : p == 1 ? 3'b010 : p == 7 ? (lit ? 3'b010 : 3'b000) : 3'b100;
  endfunction

  function automatic logic [2:0] side_of(int p, int e);
    bit lit;
    lit = ((e - 1) / FLASH) % 2 == 0;
    return p == 4 ? 3'b001 : p == 5 ? 3'b010 : p == 7 ? (lit ? 3'b100 : 3'b000) : 3'b100;
  endfunction

  // model: each phase lasts its listed duration; requests latch until their phase is entered
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_p <= 0;
      m_e <= 1;
      m_sp <= 1'b0;
      m_pp <= 1'b0;
    end else begin
      m_p <= next_phase(m_p, m_e, m_sp, m_pp, night_mode);
      m_e <= next_phase(m_p, m_e, m_sp, m_pp, night_mode) != m_p ? 1 : m_e + 1;
      m_sp <= (next_phase(m_p, m_e, m_sp, m_pp, night_mode) == 4 && m_p != 4) ? 1'b0 :
              (side_car && m_p != 4 && m_p != 5) ? 1'b1 : m_sp;
      m_pp <= (next_phase(m_p, m_e, m_sp, m_pp, night_mode) == 3 && m_p != 3) ? 1'b0 :
              (ped_req && m_p != 3) ? 1'b1 : m_pp;
    end

  // every cycle out of reset: outputs against the model plus safety invariants
  always @(negedge clk)
    if (rst_n) begin
      cmp("mdl_phase", 8'(phase), 8'(m_p));
      cmp("mdl_main", 8'(main_light), 8'(main_of(m_p, m_e)));
      cmp("mdl_side", 8'(side_light), 8'(side_of(m_p, m_e)));
      cmp("mdl_walk", 8'(walk), 8'(m_p == 3));
      cmp("inv_conflict", 8'(main_light[1:0] != 0 && side_light[1:0] != 0), 8'd0);
      cmp("inv_walk", 8'(walk && !(main_light == 3'b100 && side_light == 3'b100)), 8'd0);
    end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic seq(input string nm, input string ph, input string mn, input string sd, input string wk);
    for (int i = 0; i < ph.len(); i++) begin
      if (i > 0) begin
        step();
        side_car = 1'b0;
        ped_req = 1'b0;
      end
      #1;
      cmp({nm, "_phase"}, 8'(phase), ph[i] - 8'd48);
      cmp({nm, "_main"}, 8'(main_light), mn[i] - 8'd48);
      cmp({nm, "_side"}, 8'(side_light), sd[i] - 8'd48);
      cmp({nm, "_walk"}, 8'(walk), wk[i] - 8'd48);
    end
  endtask

  task automatic hold(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      #1;
      cmp({nm, "_phase"}, 8'(phase), 8'd0);
      cmp({nm, "_main"}, 8'(main_light), 8'd1);
      cmp({nm, "_side"}, 8'(side_light), 8'd4);
      cmp({nm, "_walk"}, 8'(walk), 8'd0);
    end
  endtask

  task automatic rst_cycle();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    side_car = 1'b0;
    ped_req = 1'b0;
    night_mode = 1'b0;
    step();
    hold("in_reset", 1);
    step();
    rst_n = 1'b1;
    night_mode = !NIGHT;
    hold("idle", 50);
    night_mode = 1'b0;

    rst_cycle();
    side_car = 1'b1;
    seq("side", "00001124445560", "11112244444441", "44444441112244", "00000000000000");

    rst_cycle();
    hold("ped_wait", 9);
    step();
    ped_req = 1'b1;
    seq("ped", "0011233360", "1122444441", "4444444444", "0000011100");

    rst_cycle();
    side_car = 1'b1;
    ped_req = 1'b1;
    seq("both", "00001123334445560", "11112244444444441", "44444444441112244", "00000001110000000");
    step();
    hold("both_after", 10);

    rst_cycle();
    side_car = 1'b1;
    seq("rst_sg", "00001124", "11112244", "44444441", "00000000");
    step();
    rst_n = 1'b0;
    seq("rst_sg_now", "0", "1", "4", "0");
    step();
    rst_n = 1'b1;
    hold("rst_sg_after", 6);

    rst_cycle();
    side_car = 1'b1;
    seq("rst_mg", "00", "11", "44", "00");
    step();
    rst_n = 1'b0;
    seq("rst_mg_now", "0", "1", "4", "0");
    step();
    rst_n = 1'b1;
    hold("rst_mg_after", 8);

`ifdef NIGHT_FLASH_EN
    rst_cycle();
    night_mode = 1'b1;
    seq("night", "000077777777", "111122220000", "444444440000", "000000000000");
    step();
    night_mode = 1'b0;
    seq("night_end", "760", "241", "444", "000");
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
